// File: rtl/sevenseg_scan_decoder_if.sv
// Display bus bundle for the 7-segment scan decoder.
// master: drives seg_in/an_in (scanning driver or bench); slave: the decoder.
interface sevenseg_scan_decoder_if;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        valid;
    logic        bad_pat;
    logic        stale;

    modport master (
        output seg_in, an_in,
        input  value, dp, valid, bad_pat, stale
    );

    modport slave (
        input  seg_in, an_in,
        output value, dp, valid, bad_pat, stale
    );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Rebuilds a 4-digit hex value from a multiplexed active-low 7-seg bus.
// Ports: clk, rst_n (sync, active low), bus (slave: seg_in/an_in in;
// value/dp/valid/bad_pat/stale out).
module sevenseg_scan_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 524288
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sevenseg_scan_decoder_if.slave  bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

    logic [7:0]    r_seg_s1, r_seg_s2, r_seg_p;
    logic [3:0]    r_an_s1, r_an_s2, r_an_p;
    logic [SW-1:0] r_stab;
    logic          r_taken;
    logic [TW-1:0] r_to;
    logic [3:0]    r_mask;
    logic [15:0]   r_slots;
    logic [3:0]    r_dps;
    logic [15:0]   r_value;
    logic [3:0]    r_dp;
    logic          r_valid;
    logic          r_bad;
    logic          r_stale;

    logic [3:0]    w_an_n;
    logic          w_one;
    logic          w_an_chg;
    logic          w_chg;
    logic          w_stab_ok;
    logic          w_accept;
    logic          w_to_hit;
    logic          w_full;
    logic [1:0]    w_idx;
    logic [4:0]    w_dec;
    logic [3:0]    w_mask_nxt;
    logic [15:0]   w_slots_nxt;
    logic [3:0]    w_dps_nxt;

    // Returns {ok, nibble} for an active-low a..g pattern.
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'b0;
        case (p)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    assign w_an_n    = ~r_an_s2;
    // Exactly one digit enable low; blank or multi-low never counts as stable.
    assign w_one     = (w_an_n != 4'b0) &&
                       ((w_an_n & (w_an_n - 4'd1)) == 4'b0);
    assign w_an_chg  = (r_an_s2 != r_an_p);
    assign w_chg     = w_an_chg || (r_seg_s2 != r_seg_p);
    assign w_stab_ok = !w_chg && w_one;
    // Accept on the cycle the counter steps onto STABLE_CYCLES.
    assign w_accept  = w_stab_ok && (r_stab == STAB_MAX - 1'b1) && !r_taken;
    assign w_to_hit  = !w_accept && (r_to == TO_MAX - 1'b1);
    assign w_full    = (r_mask == 4'hF);
    assign w_dec     = f_decode(r_seg_s2[7:1]);

    always_comb begin
        w_idx = 2'd0;
        if (w_an_n[1])      w_idx = 2'd1;
        else if (w_an_n[2]) w_idx = 2'd2;
        else if (w_an_n[3]) w_idx = 2'd3;
    end

    always_comb begin
        w_mask_nxt  = w_full ? 4'h0 : r_mask;
        w_slots_nxt = r_slots;
        w_dps_nxt   = r_dps;
        if (w_accept) begin
            if (w_dec[4]) begin
                w_mask_nxt[w_idx]               = 1'b1;
                w_slots_nxt[{w_idx, 2'b00} +: 4] = w_dec[3:0];
                w_dps_nxt[w_idx]                = ~r_seg_s2[0];
            end else begin
                w_mask_nxt  = 4'h0;
                w_slots_nxt = 16'h0;
                w_dps_nxt   = 4'h0;
            end
        end else if (w_to_hit) begin
            w_mask_nxt  = 4'h0;
            w_slots_nxt = 16'h0;
            w_dps_nxt   = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_s1 <= 8'h0;
            r_seg_s2 <= 8'h0;
            r_seg_p  <= 8'h0;
            r_an_s1  <= 4'h0;
            r_an_s2  <= 4'h0;
            r_an_p   <= 4'h0;
            r_stab   <= '0;
            r_taken  <= 1'b0;
            r_to     <= '0;
            r_mask   <= 4'h0;
            r_slots  <= 16'h0;
            r_dps    <= 4'h0;
            r_value  <= 16'h0;
            r_dp     <= 4'h0;
            r_valid  <= 1'b0;
            r_bad    <= 1'b0;
            r_stale  <= 1'b1;
        end else begin
            r_seg_s1 <= bus.seg_in;
            r_seg_s2 <= r_seg_s1;
            r_seg_p  <= r_seg_s2;
            r_an_s1  <= bus.an_in;
            r_an_s2  <= r_an_s1;
            r_an_p   <= r_an_s2;

            if (!w_stab_ok)            r_stab <= '0;
            else if (r_stab != STAB_MAX) r_stab <= r_stab + 1'b1;

            if (w_an_chg)      r_taken <= 1'b0;
            else if (w_accept) r_taken <= 1'b1;

            if (w_accept)            r_to <= '0;
            else if (r_to != TO_MAX) r_to <= r_to + 1'b1;

            r_mask  <= w_mask_nxt;
            r_slots <= w_slots_nxt;
            r_dps   <= w_dps_nxt;

            r_valid <= w_full;
            r_bad   <= w_accept && !w_dec[4];
            if (w_full) begin
                r_value <= r_slots;
                r_dp    <= r_dps;
                r_stale <= 1'b0;
            end
            if (w_to_hit) r_stale <= 1'b1;
        end
    end

    assign bus.value   = r_value;
    assign bus.dp      = r_dp;
    assign bus.valid   = r_valid;
    assign bus.bad_pat = r_bad;
    assign bus.stale   = r_stale;
endmodule
